runup_sequencer: RTL and testbench

//   Conversion sequencer for the multi-slope front end. It sits directly upstream of the PWM

---
 rtl/runup_sequencer_if.sv | 31 +++
 rtl/runup_sequencer.sv | 142 ++++++++++++++
 tb/tb_runup_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/runup_sequencer_if.sv
// Sequencer-facing bundle: conversion request, comparator, PWM control,
// run-down reference control and the valid/ready result port.
interface runup_sequencer_if;
    logic        conv_start;
    logic        comp;
    logic        pwm_start;
    logic        pwm_enable;
    logic        pwm_mode;
    logic        pwm_reload;
    logic        rundown_en;
    logic        rundown_pol;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_cnt_a;
    logic [31:0] res_cnt_b;
    logic [15:0] res_rd;
    logic        res_timeout;

    modport slave (
        input  conv_start, comp, res_ready,
        output pwm_start, pwm_enable, pwm_mode, pwm_reload, rundown_en, rundown_pol, busy,
        output res_valid, res_cnt_a, res_cnt_b, res_rd, res_timeout
    );

    modport master (
        output conv_start, comp, res_ready,
        input  pwm_start, pwm_enable, pwm_mode, pwm_reload, rundown_en, rundown_pol, busy,
        input  res_valid, res_cnt_a, res_cnt_b, res_rd, res_timeout
    );
endinterface

// File: rtl/runup_sequencer.sv
// Multi-slope conversion sequencer: drives the PWM generator through NCYCLES run-up
// periods, then a timed run-down, and returns the counts through a valid/ready port.
module runup_sequencer #(
    parameter int unsigned PERIOD  = 259,
    parameter int unsigned NCYCLES = 1000,
    parameter int unsigned RD_MAX  = 4095
) (
    input  logic              clk,
    input  logic              rst,
    runup_sequencer_if.slave  bus
);

    localparam int unsigned PcntW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PcntW-1:0] PcntLast = PcntW'(PERIOD - 1);
    localparam logic [31:0]      NcycLast = 32'(NCYCLES - 1);
    localparam logic [15:0]      RdMax    = 16'(RD_MAX);

    typedef enum logic [2:0] {StIdle, StArm, StRunup, StRundown, StDone} state_e;

    state_e           state;
    logic             comp_q1;
    logic             comp_s;
    logic [PcntW-1:0] pcnt;
    logic [31:0]      ncyc;
    logic [31:0]      cnt_a;
    logic [31:0]      cnt_b;
    logic [15:0]      rdcnt;

    logic [15:0]      rd_next;
    logic             rd_flip;
    logic             rd_tmo;
    logic [PcntW-1:0] pcnt_inc;

    // rd_next counts the current run-down cycle, so res_rd equals the cycles spent in RUNDOWN.
    assign rd_next  = rdcnt + 16'd1;
    assign rd_flip  = comp_s != bus.rundown_pol;
    assign rd_tmo   = rd_next == RdMax;
    assign pcnt_inc = pcnt + PcntW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= StIdle;
            comp_q1         <= 1'b0;
            comp_s          <= 1'b0;
            pcnt            <= '0;
            ncyc            <= '0;
            cnt_a           <= '0;
            cnt_b           <= '0;
            rdcnt           <= '0;
            bus.pwm_start   <= 1'b0;
            bus.pwm_enable  <= 1'b0;
            bus.pwm_mode    <= 1'b0;
            bus.pwm_reload  <= 1'b0;
            bus.rundown_en  <= 1'b0;
            bus.rundown_pol <= 1'b0;
            bus.busy        <= 1'b0;
            bus.res_valid   <= 1'b0;
            bus.res_cnt_a   <= '0;
            bus.res_cnt_b   <= '0;
            bus.res_rd      <= '0;
            bus.res_timeout <= 1'b0;
        end else begin
            comp_q1       <= bus.comp;
            comp_s        <= comp_q1;
            bus.pwm_start <= 1'b0;

            case (state)
                StIdle: begin
                    if (bus.conv_start) begin
                        state         <= StArm;
                        bus.pwm_start <= 1'b1;
                        bus.pwm_mode  <= 1'b0;
                        bus.busy      <= 1'b1;
                    end
                end

                StArm: begin
                    cnt_a          <= '0;
                    cnt_b          <= '0;
                    pcnt           <= '0;
                    ncyc           <= '0;
                    rdcnt          <= '0;
                    bus.pwm_mode   <= 1'b0;
                    bus.pwm_enable <= 1'b1;
                    bus.pwm_reload <= (PcntLast == '0);
                    state          <= StRunup;
                end

                StRunup: begin
                    if (pcnt == PcntLast) begin
                        if (bus.pwm_mode) begin
                            cnt_b <= cnt_b + 32'd1;
                        end else begin
                            cnt_a <= cnt_a + 32'd1;
                        end
                        ncyc <= ncyc + 32'd1;
                        pcnt <= '0;
                        if (ncyc == NcycLast) begin
                            // Final period: mode is left as-is and the PWM is released.
                            state           <= StRundown;
                            bus.pwm_enable  <= 1'b0;
                            bus.pwm_reload  <= 1'b0;
                            bus.rundown_en  <= 1'b1;
                            bus.rundown_pol <= comp_s;
                        end else begin
                            bus.pwm_mode   <= comp_s;
                            bus.pwm_reload <= (PcntLast == '0);
                        end
                    end else begin
                        pcnt           <= pcnt_inc;
                        bus.pwm_reload <= (pcnt_inc == PcntLast);
                    end
                end

                StRundown: begin
                    rdcnt <= rd_next;
                    if (rd_flip || rd_tmo) begin
                        state           <= StDone;
                        bus.rundown_en  <= 1'b0;
                        bus.res_valid   <= 1'b1;
                        bus.res_cnt_a   <= cnt_a;
                        bus.res_cnt_b   <= cnt_b;
                        bus.res_rd      <= rd_next;
                        // A comparator crossing on the timeout cycle still counts as a crossing.
                        bus.res_timeout <= !rd_flip;
                    end
                end

                StDone: begin
                    if (bus.res_ready) begin
                        state         <= StIdle;
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_runup_sequencer.sv
// Directed bench for runup_sequencer with PERIOD=10, NCYCLES=4, RD_MAX=20.
module tb_runup_sequencer;

    localparam int unsigned PERIOD  = 10;
    localparam int unsigned NCYCLES = 4;
    localparam int unsigned RD_MAX  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    runup_sequencer_if bus();

    runup_sequencer #(
        .PERIOD  (PERIOD),
        .NCYCLES (NCYCLES),
        .RD_MAX  (RD_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int         n_start;
    int         n_enable;
    int         n_reload;
    int         n_rd;
    int         bad_gap;
    int         cyc;
    int         last_reload;
    logic [7:0] mode_hist;
    logic       pol_seen;
    logic       got_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_flags();
        return {23'b0, bus.pwm_start, bus.pwm_enable, bus.pwm_mode, bus.pwm_reload,
                bus.rundown_en, bus.rundown_pol, bus.busy, bus.res_valid, bus.res_timeout};
    endfunction

    function automatic logic [31:0] res_all();
        return bus.res_cnt_a | bus.res_cnt_b | {16'b0, bus.res_rd};
    endfunction

    task automatic start_conv();
        @(negedge clk);
        bus.conv_start = 1'b1;
    endtask

    // plan 0: nothing, 1: drop comp in run-down cycle 5,
    // 2: toggle comp on every reload, 3: stray conv_start mid run-up
    task automatic run_to_valid(input int plan, input int budget);
        n_start = 0; n_enable = 0; n_reload = 0; n_rd = 0; bad_gap = 0;
        cyc = 0; last_reload = 0; mode_hist = '0; pol_seen = 1'b0; got_valid = 1'b0;
        for (int i = 0; i < budget && !got_valid; i++) begin
            @(negedge clk);
            bus.conv_start = 1'b0;
            if (bus.res_valid) begin
                got_valid = 1'b1;
            end else begin
                if (bus.pwm_start) n_start++;
                if (bus.pwm_enable) n_enable++;
                if (bus.pwm_reload) begin
                    if (n_reload > 0 && (cyc - last_reload) != int'(PERIOD)) bad_gap++;
                    last_reload = cyc;
                    mode_hist = {mode_hist[6:0], bus.pwm_mode};
                    n_reload++;
                    if (plan == 2) bus.comp = ~bus.comp;
                end
                if (bus.rundown_en) begin
                    n_rd++;
                    if (n_rd == 1) pol_seen = bus.rundown_pol;
                    if (plan == 1 && n_rd == 5) bus.comp = 1'b0;
                end
                if (plan == 3 && n_enable == 15) bus.conv_start = 1'b1;
                cyc++;
            end
        end
        check("result_valid_in_budget", {31'b0, got_valid}, 32'd1);
    endtask

    task automatic finish_result(input int hold, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] rd, input logic to);
        int unstable;
        check("res_cnt_a", bus.res_cnt_a, a);
        check("res_cnt_b", bus.res_cnt_b, b);
        check("res_rd", {16'b0, bus.res_rd}, rd);
        check("res_timeout", {31'b0, bus.res_timeout}, {31'b0, to});
        check("sum_ab", bus.res_cnt_a + bus.res_cnt_b, NCYCLES);
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.res_valid || bus.res_cnt_a != a || bus.res_cnt_b != b ||
                {16'b0, bus.res_rd} != rd || bus.res_timeout != to || !bus.busy) unstable++;
        end
        if (hold > 0) check("hold_stable", unstable, 0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("valid_dropped", {31'b0, bus.res_valid}, 32'd0);
        check("idle_not_busy", {31'b0, bus.busy}, 32'd0);
        check("res_kept_idle", bus.res_cnt_a, a);
    endtask

    initial begin
        int quiet;
        bus.conv_start = 1'b0;
        bus.comp       = 1'b0;
        bus.res_ready  = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_flags", out_flags(), 32'd0);
        check("reset_res", res_all(), 32'd0);
        rst = 1'b0;

        // comp low: all narrow periods, run-down times out
        start_conv();
        run_to_valid(0, 200);
        check("t1_start_pulses", n_start, 1);
        check("t1_runup_cycles", n_enable, 40);
        check("t1_reloads", n_reload, 4);
        check("t1_reload_gap", bad_gap, 0);
        check("t1_modes", {28'b0, mode_hist[3:0]}, 32'h0);
        check("t1_rundown_cycles", n_rd, 20);
        check("t1_pol", {31'b0, pol_seen}, 32'd0);
        finish_result(0, 4, 0, 20, 1'b0 | 1'b1);

        // comp high, dropped in run-down cycle 5: comp_s flips in cycle 7
        bus.comp = 1'b1;
        repeat (3) @(negedge clk);
        start_conv();
        run_to_valid(1, 200);
        check("t2_modes", {28'b0, mode_hist[3:0]}, 32'h7);
        check("t2_pol", {31'b0, pol_seen}, 32'd1);
        check("t2_rundown_cycles", n_rd, 7);
        finish_result(10, 1, 3, 7, 1'b0);

        // stray conv_start in RUNUP and in DONE
        bus.comp = 1'b0;
        repeat (3) @(negedge clk);
        start_conv();
        run_to_valid(3, 200);
        check("t3_start_pulses", n_start, 1);
        bus.conv_start = 1'b1;
        @(negedge clk);
        bus.conv_start = 1'b0;
        check("t3_still_done", {30'b0, bus.res_valid, bus.busy}, 32'd3);
        finish_result(0, 4, 0, 20, 1'b1);
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.busy || bus.pwm_start || bus.res_valid) quiet++;
        end
        check("t3_no_second_run", quiet, 0);

        // reset mid run-up aborts with no result
        start_conv();
        @(negedge clk);
        bus.conv_start = 1'b0;
        repeat (17) @(negedge clk);
        check("t4_in_runup", {31'b0, bus.pwm_enable}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_reset_flags", out_flags(), 32'd0);
        check("t4_reset_res", res_all(), 32'd0);
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.busy || bus.res_valid) quiet++;
        end
        check("t4_stays_idle", quiet, 0);
        start_conv();
        run_to_valid(0, 200);
        check("t4_reloads", n_reload, 4);
        finish_result(0, 4, 0, 20, 1'b1);

        // comp toggling each period: modes 0,1,0,1; comp_s crosses in run-down cycle 2
        bus.comp = 1'b1;
        repeat (3) @(negedge clk);
        start_conv();
        run_to_valid(2, 200);
        check("t5_modes", {28'b0, mode_hist[3:0]}, 32'h5);
        check("t5_pol", {31'b0, pol_seen}, 32'd0);
        check("t5_rundown_cycles", n_rd, 2);
        finish_result(0, 2, 2, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
